ib_iter_scheduler: RTL
======================

Name: ib_iter_scheduler

Overview:
- Decoding-iteration controller that sequences the per-iteration IB-map RAM updates of the check-node and variable-node write FSMs.
- For each iteration it runs the CN write unit to completion, then the VN write unit to completion. It then checks early termination and the iteration limit, and finally issues a termination to both write FSMs.
- Sits above the cnu/vnu write FSMs and drives their iter_rqst/iter_termination inputs from their 2-bit busy status.

Parameters:
- MAX_ITER, 10, maximum decoding iterations per codeword (≥1).
- ITER_WIDTH, $clog2(MAX_ITER+1), width of iter_cnt.
- WDOG_CYCLES, 256, watchdog limit in cycles per update phase; used only with IB_SCHED_WDOG_EN.

Ports:
- write_clk  in  1  sole clock, shared with the write FSMs.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins decoding of one codeword; ignored unless state is IDLE.
- early_term  in  1  syndrome-satisfied flag, sampled only in ITER_CHK.
- cn_busy  in  2  CN write FSM status: 00 idle, 01 updating, 10 finish.
- vn_busy  in  2  VN write FSM status, same encoding as cn_busy.
- cn_iter_rqst  out  1  request to CN write FSM; held high for the whole update.
- vn_iter_rqst  out  1  request to VN write FSM; held high for the whole update.
- iter_termination  out  1  termination to both write FSMs.
- iter_cnt  out  ITER_WIDTH  completed iterations.
- done  out  1  one-cycle pulse at the end of a codeword.
- timeout_err  out  1  sticky watchdog error.
- state  out  3  current state, for debug.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, iter_cnt=0, all single-bit outputs 0, phase_seen=0, watchdog counter=0.
  - Reset mid-operation aborts immediately.
  - Both rqst outputs drop while rstn is low, so the write FSMs return to IDLE.
- Outputs: Moore decode of the state register, except iter_cnt and timeout_err, which are registers.
- States and encoding: IDLE=000, CN_UPD=001, VN_UPD=010, ITER_CHK=011, TERM=100.
- IDLE:
  - All outputs 0.
  - On start: iter_cnt<=0, timeout_err<=0, phase_seen<=0, next state CN_UPD.
  - Latency: start at cycle N gives cn_iter_rqst=1 at cycle N+1.
- CN_UPD:
  - cn_iter_rqst=1.
  - phase_seen is set when cn_busy==01.
  - Phase completes on cn_busy==10 with phase_seen=1. Then clear phase_seen and go to VN_UPD.
  - cn_busy==10 while phase_seen=0 is a stale FINISH from the previous iteration and is ignored.
  - cn_iter_rqst drops the cycle after completion; the write FSM's own FINISH→IDLE step covers this.
- VN_UPD:
  - vn_iter_rqst=1; same phase_seen rules as CN_UPD, applied to vn_busy.
  - On completion, go to ITER_CHK.
- ITER_CHK:
  - Both rqst low; iter_cnt<=iter_cnt+1.
  - If early_term=1 or iter_cnt+1==MAX_ITER, go to TERM; otherwise go to CN_UPD.
  - early_term and the limit hitting together: go to TERM (same result).
- TERM:
  - iter_termination=1 and done=1 for exactly one cycle; both rqst=0. Next state IDLE.
  - iter_cnt holds its final value until the next start.
- start while not IDLE: ignored, no side effects.
- iter_cnt never wraps: the maximum value reached is MAX_ITER.
- Nominal iteration cost with 64-cycle write units: about 2×(64+3)+1 cycles.

Optional Feature:
- Macro: IB_SCHED_WDOG_EN.
- Defined:
  - A phase counter clears on entry to CN_UPD/VN_UPD and increments each cycle in those states.
  - When it reaches WDOG_CYCLES-1 without phase completion: timeout_err<=1 (sticky until the next start), state goes to TERM, and iter_termination/done pulse as normal.
- Undefined:
  - No counter is built and timeout_err is tied 0.
  - The scheduler waits indefinitely for busy==10.

Test Plan:
- MAX_ITER=3, bench write FSMs 64-cycle, early_term=0; start pulse → cn_iter_rqst high at +1 cycle; 3 CN→VN pairs in order; iter_cnt ends at 3; one done pulse with iter_termination=1; state returns to 000.
- early_term=1 from the first ITER_CHK → exactly one CN and one VN update, iter_cnt=1, done pulse, no further cn_iter_rqst.
- Stale FINISH: hold cn_busy=10 for the first 2 cycles of CN_UPD, then 01 for 64 cycles, then 10 → scheduler stays in CN_UPD until the second 10; the transition to VN_UPD occurs only then.
- start pulsed during VN_UPD → no state change, iter_cnt unchanged, no extra done.
- rstn low for 1 cycle mid CN_UPD → all outputs 0 asynchronously, state=000, iter_cnt=0; a following start restarts cleanly.
- IB_SCHED_WDOG_EN, WDOG_CYCLES=16, vn_busy stuck at 01 → after 16 cycles in VN_UPD: timeout_err=1, iter_termination and done pulse once; timeout_err holds until the next start clears it.

Source files
------------

// File: rtl/ib_iter_scheduler.sv
// ib_iter_scheduler: sequences per-iteration CN then VN IB-map write updates, early termination and iteration limit.
// Optional per-phase watchdog is built only when IB_SCHED_WDOG_EN is defined.
module ib_iter_scheduler #(
    parameter int MAX_ITER    = 10,
    parameter int ITER_WIDTH  = $clog2(MAX_ITER + 1),
    parameter int WDOG_CYCLES = 256
) (
    input  logic                  write_clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  early_term,
    input  logic [1:0]            cn_busy,
    input  logic [1:0]            vn_busy,
    output logic                  cn_iter_rqst,
    output logic                  vn_iter_rqst,
    output logic                  iter_termination,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  done,
    output logic                  timeout_err,
    output logic [2:0]            state
);

    localparam logic [2:0] ST_IDLE     = 3'b000;
    localparam logic [2:0] ST_CN_UPD   = 3'b001;
    localparam logic [2:0] ST_VN_UPD   = 3'b010;
    localparam logic [2:0] ST_ITER_CHK = 3'b011;
    localparam logic [2:0] ST_TERM     = 3'b100;

    localparam logic [1:0] BUSY_UPD = 2'b01;
    localparam logic [1:0] BUSY_FIN = 2'b10;

    localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(MAX_ITER);
    localparam logic [ITER_WIDTH-1:0] ITER_ONE  = ITER_WIDTH'(1);

    logic [2:0]            r_state;
    logic [ITER_WIDTH-1:0] r_iter_cnt;
    logic                  r_phase_seen;

    logic [2:0]            w_state_nxt;
    logic [ITER_WIDTH-1:0] w_iter_cnt_nxt;
    logic                  w_phase_seen_nxt;
    logic [ITER_WIDTH-1:0] w_iter_inc;
    logic [1:0]            w_busy_sel;
    logic                  w_in_phase;
    logic                  w_phase_done;
    logic                  w_wdog_exp;

    assign w_in_phase   = (r_state == ST_CN_UPD) || (r_state == ST_VN_UPD);
    assign w_busy_sel   = (r_state == ST_VN_UPD) ? vn_busy : cn_busy;
    // A FINISH only counts once this phase has seen UPDATING; earlier ones are stale.
    assign w_phase_done = w_in_phase && r_phase_seen && (w_busy_sel == BUSY_FIN);
    assign w_iter_inc   = r_iter_cnt + ITER_ONE;

    // Next-state and iteration bookkeeping.
    always_comb begin
        w_state_nxt      = r_state;
        w_iter_cnt_nxt   = r_iter_cnt;
        w_phase_seen_nxt = r_phase_seen;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt      = ST_CN_UPD;
                    w_iter_cnt_nxt   = {ITER_WIDTH{1'b0}};
                    w_phase_seen_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CN_UPD, ST_VN_UPD: begin
                if (w_phase_done) begin
                    w_phase_seen_nxt = 1'b0;
                    w_state_nxt      = (r_state == ST_CN_UPD) ? ST_VN_UPD : ST_ITER_CHK;
                end else if (w_wdog_exp) begin
                    w_state_nxt = ST_TERM;
                end else if (w_busy_sel == BUSY_UPD) begin
                    w_phase_seen_nxt = 1'b1;
                end else begin
                    w_phase_seen_nxt = r_phase_seen;
                end
            end
            ST_ITER_CHK: begin
                w_iter_cnt_nxt = w_iter_inc;
                if (early_term || (w_iter_inc == ITER_LAST)) begin
                    w_state_nxt = ST_TERM;
                end else begin
                    w_state_nxt = ST_CN_UPD;
                end
            end
            ST_TERM: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Core state registers.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_iter_cnt   <= {ITER_WIDTH{1'b0}};
            r_phase_seen <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_iter_cnt   <= w_iter_cnt_nxt;
            r_phase_seen <= w_phase_seen_nxt;
        end
    end

`ifdef IB_SCHED_WDOG_EN
    localparam int WDOG_WIDTH = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(WDOG_CYCLES - 1);
    localparam logic [WDOG_WIDTH-1:0] WDOG_ONE  = WDOG_WIDTH'(1);

    logic [WDOG_WIDTH-1:0] r_wdog_cnt;
    logic                  r_timeout_err;

    assign w_wdog_exp  = w_in_phase && (r_wdog_cnt == WDOG_LAST);
    assign timeout_err = r_timeout_err;

    // Phase watchdog: restarts on every phase entry, sticky error until next start.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog_cnt    <= {WDOG_WIDTH{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_timeout_err <= 1'b0;
            end else if (w_wdog_exp && !w_phase_done) begin
                r_timeout_err <= 1'b1;
            end else begin
                r_timeout_err <= r_timeout_err;
            end
            if (w_in_phase && (w_state_nxt == r_state)) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_ONE;
            end else begin
                r_wdog_cnt <= {WDOG_WIDTH{1'b0}};
            end
        end
    end
`else
    assign w_wdog_exp  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign cn_iter_rqst     = (r_state == ST_CN_UPD);
    assign vn_iter_rqst     = (r_state == ST_VN_UPD);
    assign iter_termination = (r_state == ST_TERM);
    assign done             = (r_state == ST_TERM);
    assign iter_cnt         = r_iter_cnt;
    assign state            = r_state;

endmodule
